// File: rtl/mem_wb_stage_pkg.sv
// Shared core types for the MEM->WB boundary: default widths, write-back entry layout, x0 constant.
// Combinational helpers only; no state, no latency, no backpressure.
package mem_wb_stage_pkg;

  localparam int XLEN_DEF       = 32;
  localparam int REG_ADDR_W_DEF = 5;
  localparam int CNT_W_DEF      = 64;

  typedef struct packed {
    logic [REG_ADDR_W_DEF-1:0] addr;
    logic [XLEN_DEF-1:0]       data;
    logic                      wen;
  } wb_entry_t;

  localparam logic [REG_ADDR_W_DEF-1:0] REG_ZERO = '0;

  // A write reaches the register file only from a held entry targeting a real register.
  function automatic logic wb_gate(input logic valid, input logic wen, input logic addr_nonzero);
    return valid & wen & addr_nonzero;
  endfunction

endpackage

// File: rtl/mem_wb_stage_skid_buf2.sv
// Generic 2-entry valid/ready skid buffer with synchronous flush; main entry drives the outputs.
// Latency 1 cycle; in_ready comes straight from the skid valid flop, so no comb ready path.
module mem_wb_stage_skid_buf2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         m_valid;
  logic         s_valid;
  logic [W-1:0] m_data;
  logic [W-1:0] s_data;
  logic         accept;
  logic         drain;

  assign in_ready  = ~s_valid;
  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign accept    = in_valid & in_ready;
  assign drain     = m_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_data  <= '0;
      s_data  <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (drain) begin
      if (s_valid) begin
        // in_ready is low here, so no accept can collide with the S->M move
        m_data  <= s_data;
        s_valid <= 1'b0;
      end else if (accept) begin
        m_data  <= in_data;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (!m_valid) begin
      if (accept) begin
        m_data  <= in_data;
        m_valid <= 1'b1;
      end
    end else if (accept) begin
      s_data  <= in_data;
      s_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline stage: skid-buffered handshake, flush, x0 write suppression, forwarding tap.
// Latency 1 cycle; WB stall fills the skid entry, then in_ready drops. MEM_WB_PERF_EN adds retire_cnt_o.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic [XLEN-1:0]       rd_data_i,
  input  logic                  rd_wen_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic [XLEN-1:0]       rd_data_o,
  output logic                  rd_wen_o,
  output logic                  fwd_valid_o,
  output logic [REG_ADDR_W-1:0] fwd_addr_o,
  output logic [XLEN-1:0]       fwd_data_o
`ifdef MEM_WB_PERF_EN
  ,
  output logic [CNT_W-1:0]      retire_cnt_o
`endif
);

  localparam int PW = REG_ADDR_W + XLEN + 1;

  if (XLEN < 1 || REG_ADDR_W < 1 || CNT_W < 1) begin : g_bad_param
    $error("mem_wb_stage: XLEN, REG_ADDR_W and CNT_W must all be >= 1");
  end

  logic [PW-1:0] in_pay;
  logic [PW-1:0] out_pay;
  logic          m_wen;

  assign in_pay = {rd_addr_i, rd_data_i, rd_wen_i};

  mem_wb_stage_skid_buf2 #(
    .W (PW)
  ) u_skid_buf2 (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush_i),
    .in_valid  (in_valid_i),
    .in_ready  (in_ready_o),
    .in_data   (in_pay),
    .out_valid (out_valid_o),
    .out_ready (out_ready_i),
    .out_data  (out_pay)
  );

  assign {rd_addr_o, rd_data_o, m_wen} = out_pay;

  // Payload stays visible when empty; only the write enable is qualified.
  assign rd_wen_o = wb_gate(out_valid_o, m_wen, rd_addr_o != REG_ADDR_W'(REG_ZERO));

  assign fwd_valid_o = rd_wen_o;
  assign fwd_addr_o  = rd_addr_o;
  assign fwd_data_o  = rd_data_o;

`ifdef MEM_WB_PERF_EN
  logic drain;

  // A drain in the flush cycle was consumed by WB, so it still retires.
  assign drain = out_valid_o & out_ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt_o <= '0;
    end else if (drain) begin
      retire_cnt_o <= retire_cnt_o + 1'b1;
    end
  end
`endif

endmodule
